// File: rtl/posit_defines.sv
// Posit<4,0> constants, pipeline stage records and the magnitude-to-code table
// shared by the quire-to-posit converter.
package posit_defines;

  localparam int          POSIT_W       = 4;
  localparam int          POSIT_ES      = 0;
  localparam logic [3:0]  POSIT_ZERO    = 4'b0000;
  localparam logic [3:0]  POSIT_NAR     = 4'b1000;
  localparam logic [3:0]  POSIT_MAXPOS  = 4'b0111;
  localparam logic [3:0]  POSIT_MINPOS  = 4'b0001;
  localparam int          QUIRE_LSB_EXP = -4;
  localparam int          NQMIN         = 9;
  localparam int          MAG_W         = 7;
  // 64 quire LSBs = 4.0 = maxpos; anything larger encodes the same.
  localparam logic [6:0]  MAG_SAT       = 7'd64;

  typedef struct packed {
    logic             valid;
    logic [MAG_W-1:0] mag;
    logic             sign;
    logic             nar;
    logic             zero;
    logic             sow;
    logic             eow;
  } stage1_t;

  typedef struct packed {
    logic               valid;
    logic [POSIT_W-1:0] posit;
    logic               nar;
    logic               sow;
    logic               eow;
  } stage2_t;

  // Round-to-nearest-even boundaries between adjacent posit values, in units of 1/16.
  // No underflow: any nonzero magnitude maps to at least minpos.
  function automatic logic [3:0] mag_code(input logic [6:0] m);
    logic [3:0] code;
    if (m == 7'd0)       code = POSIT_ZERO;
    else if (m <= 7'd5)  code = POSIT_MINPOS;
    else if (m <= 7'd10) code = 4'b0010;
    else if (m <= 7'd13) code = 4'b0011;
    else if (m <= 7'd20) code = 4'b0100;
    else if (m <= 7'd27) code = 4'b0101;
    else if (m <= 7'd48) code = 4'b0110;
    else                 code = POSIT_MAXPOS;
    return code;
  endfunction

endpackage

// File: rtl/quire_to_posit_4_0_if.sv
// Upstream (quire beats) and downstream (posit beats) streaming signals of the converter.
interface quire_to_posit_4_0_if #(
  parameter int QW = 19
);
  // Handshake: a beat moves when the sender's rts and the receiver's rtr are both
  // high at a rising clk edge; payload and window marks are qualified by rts.
  logic          rts_i;
  logic          rtr_o;
  logic          sow_i;
  logic          eow_i;
  logic [QW-1:0] data_i;
  logic          sign_i;
  logic          zero_i;
  logic          NaR_i;
  logic          rtr_i;
  logic          rts_o;
  logic          sow_o;
  logic          eow_o;
  logic [3:0]    posit_o;
  logic          NaR_o;

  modport slave (
    input  rts_i, sow_i, eow_i, data_i, sign_i, zero_i, NaR_i, rtr_i,
    output rtr_o, rts_o, sow_o, eow_o, posit_o, NaR_o
  );

  modport master (
    output rts_i, sow_i, eow_i, data_i, sign_i, zero_i, NaR_i, rtr_i,
    input  rtr_o, rts_o, sow_o, eow_o, posit_o, NaR_o
  );

endinterface

// File: rtl/posit4_round_encode.sv
// Stage-2 combinational encoder: saturated quire magnitude plus flags to posit<4,0>.
module posit4_round_encode
  import posit_defines::*;
(
  input  logic [6:0] m,
  input  logic       sign,
  input  logic       zero,
  input  logic       NaR,
  output logic [3:0] posit
);

  logic [3:0] code;

  always_comb begin
    posit = POSIT_ZERO;
    code  = mag_code(m);
    if (NaR)
      posit = POSIT_NAR;
    else if (zero || (m == 7'd0))
      posit = POSIT_ZERO;
    else if (sign)
      posit = ~code + 4'd1;
    else
      posit = code;
  end

endmodule

// File: rtl/quire_to_posit_4_0.sv
// Two-stage quire-to-posit<4,0> converter with rts/rtr flow control.
// Define QUIRE_TO_POSIT_EOW_ONLY_EN to emit only the end-of-window beat of each window.
module quire_to_posit_4_0
  import posit_defines::*;
#(
  parameter int LOG_NB_ACCUM = 10
) (
  input logic                  clk,
  input logic                  rst_n,
  quire_to_posit_4_0_if.slave  bus
);

  localparam int QW = 9 + LOG_NB_ACCUM;

  logic          process_en;
  logic          receive_en;
  logic          accept;
  logic          s1_load;
  logic          rtr_q;
  logic [QW-1:0] abs_val;
  logic [6:0]    mag_sat;
  logic [3:0]    enc_posit;
  stage1_t       s1_q;
  stage2_t       s2_q;

  // The whole pipeline advances together whenever the output slot can move.
  assign process_en = bus.rtr_i | ~s2_q.valid;
  assign receive_en = bus.rts_i & rtr_q;
  assign accept     = receive_en & process_en;

`ifdef QUIRE_TO_POSIT_EOW_ONLY_EN
  assign s1_load = accept & bus.eow_i;
`else
  assign s1_load = accept;
`endif

  // The most-negative quire negates to itself, whose unsigned value is far above 64.
  always_comb begin
    abs_val = bus.data_i[QW-1] ? (~bus.data_i + QW'(1)) : bus.data_i;
    mag_sat = (abs_val >= QW'(MAG_SAT)) ? MAG_SAT : abs_val[6:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rtr_q <= 1'b0;
      s1_q  <= '0;
      s2_q  <= '0;
    end else begin
      rtr_q <= process_en;
      if (process_en) begin
        s1_q.valid <= s1_load;
        if (s1_load) begin
          s1_q.mag  <= mag_sat;
          s1_q.sign <= bus.sign_i;
          s1_q.nar  <= bus.NaR_i;
          s1_q.zero <= bus.zero_i;
          s1_q.sow  <= bus.sow_i;
          s1_q.eow  <= bus.eow_i;
        end
        s2_q.valid <= s1_q.valid;
        if (s1_q.valid) begin
          s2_q.posit <= enc_posit;
          s2_q.nar   <= s1_q.nar;
          s2_q.sow   <= s1_q.sow;
          s2_q.eow   <= s1_q.eow;
        end
      end
    end
  end

  posit4_round_encode u_encode (
    .m     (s1_q.mag),
    .sign  (s1_q.sign),
    .zero  (s1_q.zero),
    .NaR   (s1_q.nar),
    .posit (enc_posit)
  );

  assign bus.rtr_o   = rtr_q;
  assign bus.rts_o   = s2_q.valid;
  assign bus.posit_o = s2_q.posit;
  assign bus.NaR_o   = s2_q.nar;
  assign bus.sow_o   = s2_q.sow;
  assign bus.eow_o   = s2_q.eow;

endmodule

// File: tb/tb_quire_to_posit_4_0.sv
// Directed bench for quire_to_posit_4_0: hand-computed posit codes, stalls, windows, reset.
module tb_quire_to_posit_4_0;

  localparam int QW = 19;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  quire_to_posit_4_0_if #(.QW(QW)) bus ();

  quire_to_posit_4_0 #(.LOG_NB_ACCUM(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] out_word();
    return {bus.NaR_o, bus.sow_o, bus.eow_o, bus.posit_o};
  endfunction

  // Drive one beat and hold it until the DUT takes it; expectation is {NaR, sow, eow, posit}.
  task automatic send(input int val, input logic z, input logic nar,
                      input logic sow, input logic eow, input logic [3:0] exp_p);
    logic acc;
    @(negedge clk);
    bus.rts_i  = 1'b1;
    bus.data_i = QW'(val);
    bus.sign_i = (val < 0);
    bus.zero_i = z;
    bus.NaR_i  = nar;
    bus.sow_i  = sow;
    bus.eow_i  = eow;
`ifdef QUIRE_TO_POSIT_EOW_ONLY_EN
    if (eow) exp_q.push_back({nar, sow, eow, exp_p});
`else
    exp_q.push_back({nar, sow, eow, exp_p});
`endif
    acc = 1'b0;
    for (int c = 0; c < 100 && !acc; c++) begin
      #4;
      acc = bus.rtr_o & (bus.rtr_i | ~bus.rts_o);
      @(posedge clk);
      if (!acc) @(negedge clk);
    end
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.rts_i = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Output scoreboard: a beat leaves when rts_o and rtr_i are high at the edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (bus.rts_o && bus.rtr_i) begin
        if (exp_q.size() == 0) check("unexpected_beat", 32'(bus.rts_o), 32'd0);
        else check("out", 32'(out_word()), 32'(exp_q.pop_front()));
      end else if (bus.rts_o && exp_q.size() != 0) begin
        check("stall_hold", 32'(out_word()), 32'(exp_q[0]));
      end
    end
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int         sv[10];
    logic [3:0] sp[10];

    bus.rts_i  = 1'b0;
    bus.rtr_i  = 1'b1;
    bus.data_i = '0;
    bus.sign_i = 1'b0;
    bus.zero_i = 1'b0;
    bus.NaR_i  = 1'b0;
    bus.sow_i  = 1'b0;
    bus.eow_i  = 1'b0;

    // Reset values, then rtr_o rises only after the first edge following release.
    repeat (2) @(negedge clk);
    #1;
    check("rst_out", 32'(out_word()), 32'd0);
    check("rst_rts", 32'(bus.rts_o), 32'd0);
    check("rst_rtr", 32'(bus.rtr_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rtr_at_release", 32'(bus.rtr_o), 32'd0);
    @(negedge clk);
    #1;
    check("rtr_ready", 32'(bus.rtr_o), 32'd1);

    // 1.0 with two-cycle latency.
    send(16, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100);
    idle();
    #1;
    check("lat1_rts", 32'(bus.rts_o), 32'd0);
    @(negedge clk);
    #1;
    check("lat2_rts", 32'(bus.rts_o), 32'd1);
    check("lat2_posit", 32'(bus.posit_o), 32'b0100);
    wait_drain();

    // Directed values and table boundaries, back to back.
    send(-6,      1'b0, 1'b0, 1'b1, 1'b1, 4'b1110);
    send(-14,     1'b0, 1'b0, 1'b0, 1'b1, 4'b1100);
    send(-48,     1'b0, 1'b0, 1'b0, 1'b1, 4'b1010);
    send(-49,     1'b0, 1'b0, 1'b0, 1'b1, 4'b1001);
    send(1,       1'b0, 1'b0, 1'b0, 1'b1, 4'b0001);
    send(200000,  1'b0, 1'b0, 1'b0, 1'b1, 4'b0111);
    send(37,      1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
    send(5,       1'b1, 1'b1, 1'b0, 1'b1, 4'b1000);
    send(5,       1'b0, 1'b0, 1'b0, 1'b1, 4'b0001);
    send(6,       1'b0, 1'b0, 1'b0, 1'b1, 4'b0010);
    send(10,      1'b0, 1'b0, 1'b0, 1'b1, 4'b0010);
    send(11,      1'b0, 1'b0, 1'b0, 1'b1, 4'b0011);
    send(13,      1'b0, 1'b0, 1'b0, 1'b1, 4'b0011);
    send(14,      1'b0, 1'b0, 1'b0, 1'b1, 4'b0100);
    send(20,      1'b0, 1'b0, 1'b0, 1'b1, 4'b0100);
    send(21,      1'b0, 1'b0, 1'b0, 1'b1, 4'b0101);
    send(27,      1'b0, 1'b0, 1'b0, 1'b1, 4'b0101);
    send(28,      1'b0, 1'b0, 1'b0, 1'b1, 4'b0110);
    send(48,      1'b0, 1'b0, 1'b0, 1'b1, 4'b0110);
    send(49,      1'b0, 1'b0, 1'b0, 1'b1, 4'b0111);
    send(64,      1'b0, 1'b0, 1'b0, 1'b1, 4'b0111);
    send(-262144, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1001);
    send(0,       1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    send(-1,      1'b0, 1'b0, 1'b0, 1'b1, 4'b1111);
    idle();
    wait_drain();

    // Ten beats with a three-cycle downstream stall in the middle.
    sv = '{3, 8, 12, 16, 22, 30, 50, -3, -16, -100};
    sp = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
           4'b0110, 4'b0111, 4'b1111, 4'b1100, 4'b1001};
    fork
      begin
        for (int i = 0; i < 10; i++) send(sv[i], 1'b0, 1'b0, (i == 0), 1'b1, sp[i]);
        idle();
      end
      begin
        repeat (4) @(negedge clk);
        bus.rtr_i = 1'b0;
        repeat (3) @(negedge clk);
        bus.rtr_i = 1'b1;
      end
    join
    wait_drain();

    // Five-beat window, eow only on the last beat.
    send(3,  1'b0, 1'b0, 1'b1, 1'b0, 4'b0001);
    send(7,  1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
    send(12, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011);
    send(30, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110);
    send(24, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0101);
    idle();
    wait_drain();

    // Reset with two beats in flight: nothing may come out afterwards.
    send(16, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0100);
    send(-6, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1110);
    idle();
    #1;
    check("inflight_rts", 32'(bus.rts_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_rts", 32'(bus.rts_o), 32'd0);
    check("async_rst_out", 32'(out_word()), 32'd0);
    check("async_rst_rtr", 32'(bus.rtr_o), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check("post_rst_rts", 32'(bus.rts_o), 32'd0);

    // Operation resumes after reset.
    send(21, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0101);
    idle();
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/quire_to_posit_4_0.md
QUIRE_TO_POSIT_4_0 -- requirements
Module: quire_to_posit_4_0

Interface
REQ-001 Parameter LOG_NB_ACCUM, default 10, sets quire width QW = 9 + LOG_NB_ACCUM (19 at default).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 rts_i  input  1  upstream beat valid.
REQ-005 rtr_o  output  1  ready to receive from upstream.
REQ-006 sow_i / eow_i  input  1 each  start/end-of-window marks of the beat.
REQ-007 data_i  input  QW  signed two's-complement quire; LSB weight 2^-4.
REQ-008 sign_i / zero_i / NaR_i  input  1 each  quire sign, all-zero and NaR flags.
REQ-009 rtr_i  input  1  downstream ready.
REQ-010 rts_o  output  1  output beat valid.
REQ-011 sow_o / eow_o  output  1 each  window marks, aligned with posit_o.
REQ-012 posit_o  output  4  posit<4,0> result.
REQ-013 NaR_o  output  1  high when posit_o is NaR (1000).

Function
REQ-014 process_en = rtr_i | ~rts_o; receive_en = rts_i & rtr_o; rtr_o is process_en registered one cycle.
REQ-015 A beat is accepted only in a cycle where receive_en and process_en are both high.
REQ-016 Two-stage pipeline; posit_o valid exactly 2 accepted-and-advanced cycles after acceptance; latency 2 with rtr_i held high.
REQ-017 Each stage loads when its predecessor holds a beat and process_en is high; clears its valid when predecessor empty and process_en high; holds all contents while process_en low.
REQ-018 With rtr_i held low and rts_o high, posit_o, NaR_o, sow_o and eow_o are stable; no beat is lost or duplicated.
REQ-019 Stage 1: registers m = |data_i| saturated to 64 (7 bits), the sign, NaR, zero, sow and eow; the most-negative data_i saturates to m = 64.
REQ-020 Stage 2 magnitude code: m=0 -> 0000; 1..5 -> 0001; 6..10 -> 0010; 11..13 -> 0011; 14..20 -> 0100; 21..27 -> 0101; 28..48 -> 0110; >=49 -> 0111.
REQ-021 Table implements round-to-nearest, ties-to-even encoding, no underflow to zero, saturation at maxpos 4.0.
REQ-022 Negative sign with nonzero m: posit_o = two's complement of the magnitude code (4-bit).
REQ-023 zero_i high forces posit_o = 0000 regardless of data_i.
REQ-024 NaR_i high forces posit_o = 1000 and NaR_o = 1, overriding zero_i and data_i.
REQ-025 sow_o/eow_o reproduce sow_i/eow_i of the same beat; a beat with both set passes both.

Reset
REQ-026 While rst_n low: rts_o=0, rtr_o=0, posit_o=0000, NaR_o=0, sow_o=0, eow_o=0, all stage valids and data registers 0.
REQ-027 Reset asserted mid-operation discards all in-flight beats immediately; first acceptance possible at the second clk edge after deassertion.

Configuration
REQ-028 Macro QUIRE_TO_POSIT_EOW_ONLY_EN defined: only beats with eow_i=1 enter stage 1; accepted beats with eow_i=0 are consumed (handshake completes) but produce no output.
REQ-029 Macro undefined: every accepted beat produces one output beat.

Structure
REQ-030 Posit<4,0> constants (width 4, es 0, NaR pattern, maxpos/minpos codes, quire LSB exponent -4, nqmin 9) belong in package posit_defines.
REQ-031 Stage-2 table is one combinational sub-module posit4_round_encode (inputs m, sign, zero, NaR; output 4-bit posit).

Verification
REQ-032 data_i=16 (1.0), sign=0, rtr_i=1 -> posit_o=0100 two cycles later, rts_o=1.
REQ-033 data_i=-6, -14, -48, -49 -> posit_o=1110, 1100, 1010, 1001.
REQ-034 data_i=1 -> 0001; data_i=200000 -> 0111; zero_i=1 -> 0000; NaR_i=1 with zero_i=1 -> 1000, NaR_o=1.
REQ-035 Ten back-to-back beats, rtr_i low for 3 cycles mid-stream -> all ten outputs in order, values held stable while stalled.
REQ-036 QUIRE_TO_POSIT_EOW_ONLY_EN defined, window of 5 beats (last data 24, eow on beat 5) -> single output 0101 with sow_o=0, eow_o=1.
REQ-037 rst_n pulsed low with two beats in flight -> rts_o=0 asynchronously; no stale beat emitted after release.
